// File: rtl/proc_defs.sv
// Shared datapath definitions for the 16-bit result-bus steering logic.
package proc_defs;

  localparam int   DATA_W   = 16;
  localparam logic CH_SEL_0 = 1'b0;
  localparam logic CH_SEL_1 = 1'b1;

  // Number of output channels fed by the demux.
  localparam int   NUM_CH   = 2;

endpackage : proc_defs

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO for the buffered demux. A full FIFO refuses a push even if
// it is popped in the same cycle; head is forced to zero while empty.
module demux_chan_fifo
  import proc_defs::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_do;
  logic             pop_do;

  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign push_do = push & ~full;
  assign pop_do  = pop & valid;
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  // Next-state for pointers (wrap modulo DEPTH) and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_do) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_do)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_do, pop_do})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset wins over any push or pop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so a stale word can never reappear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_do) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule : demux_chan_fifo

// File: rtl/demux_16bit_1to2_buf.sv
// Buffered 1-to-2 demux: steers each accepted word to one of two FIFOs by
// In_Sel so that a stalled consumer only blocks its own channel.
module demux_16bit_1to2_buf
  import proc_defs::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out0_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out1_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic             Busy
);

  logic full0, full1;
  logic push0, push1;
  logic accept;

  // In_Ready depends only on In_Sel and registered fullness, never on In_Valid.
  assign In_Ready = (In_Sel == CH_SEL_1) ? ~full1 : ~full0;
  assign accept   = In_Valid & In_Ready;
  assign push0    = accept & (In_Sel == CH_SEL_0);
  assign push1    = accept & (In_Sel == CH_SEL_1);
  assign Busy     = Out0_Valid | Out1_Valid;

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan0 (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push0),
    .push_data (In_Data),
    .full      (full0),
    .pop       (Out0_Ready),
    .head      (Out0_Data),
    .valid     (Out0_Valid)
  );

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push1),
    .push_data (In_Data),
    .full      (full1),
    .pop       (Out1_Ready),
    .head      (Out1_Data),
    .valid     (Out1_Valid)
  );

endmodule : demux_16bit_1to2_buf
